// File: rtl/moore_seq_gen_pkg.sv
// Shared types and constants for the moore_seq_gen serial pattern transmitter.
package moore_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Fibonacci LFSR, taps 8,6,5,4 -> state bits 7,5,4,3
  localparam int unsigned     LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned       DEF_PAT_W     = 4;
  localparam int unsigned       DEF_CNT_W     = 4;
  localparam int unsigned       DEF_GAP_W     = 4;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/moore_seq_gen_lfsr.sv
// 8-bit Fibonacci LFSR with advance enable; used for gap fill in moore_seq_gen.
module seq_gen_lfsr
  import moore_seq_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_LFSR_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic out_bit
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out_bit = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern transmitter: MSB-first pattern, repeat count, idle gap.
// Optional LFSR gap fill enabled by defining MOORE_SEQ_GEN_GAP_LFSR_EN.
module moore_seq_gen
  import moore_seq_gen_pkg::*;
#(
  parameter int unsigned       PAT_W     = DEF_PAT_W,
  parameter int unsigned       CNT_W     = DEF_CNT_W,
  parameter int unsigned       GAP_W     = DEF_GAP_W,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("moore_seq_gen: LFSR_SEED must be nonzero");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             x_out_q, x_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_dec;
  logic             gap_fill_bit;

`ifdef MOORE_SEQ_GEN_GAP_LFSR_EN
  logic lfsr_adv;

  seq_gen_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst),
    .en      (lfsr_adv),
    .out_bit (gap_fill_bit)
  );
`else
  assign gap_fill_bit = 1'b0;
`endif

  assign idx_dec = bit_idx_q - 1'b1;

  // Outputs are computed for the next state and registered with it, so each
  // output is a pure function of the registered state and counters.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    rep_d         = rep_q;
    gap_cnt_d     = gap_cnt_q;
    pat_d         = pat_q;
    gap_d         = gap_q;
    x_out_d       = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pat_d = pattern;
          gap_d = gap_len;
          rep_d = repeat_cnt;
          if (repeat_cnt != '0) begin
            state_d       = ST_SEND;
            bit_idx_d     = MSB_IDX;
            x_out_d       = pattern[PAT_W-1];
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d   = idx_dec;
          x_out_d     = pat_q[idx_dec];
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (rep_q == CNT_W'(1)) begin
          rep_d   = '0;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          rep_d  = rep_q - 1'b1;
          busy_d = 1'b1;
          if (gap_q == '0) begin
            bit_idx_d     = MSB_IDX;
            x_out_d       = pat_q[PAT_W-1];
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
            x_out_d   = gap_fill_bit;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d       = ST_SEND;
          gap_cnt_d     = '0;
          bit_idx_d     = MSB_IDX;
          x_out_d       = pat_q[PAT_W-1];
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          x_out_d   = gap_fill_bit;
          busy_d    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef MOORE_SEQ_GEN_GAP_LFSR_EN
    // One LFSR step per GAP cycle: the bit shown is consumed as it is loaded.
    lfsr_adv = (state_d == ST_GAP);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      rep_q         <= '0;
      gap_cnt_q     <= '0;
      pat_q         <= '0;
      gap_q         <= '0;
      x_out_q       <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      rep_q         <= rep_d;
      gap_cnt_q     <= gap_cnt_d;
      pat_q         <= pat_d;
      gap_q         <= gap_d;
      x_out_q       <= x_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign x_out       = x_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: vector table plus hand-written corner sequences.
module tb_moore_seq_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             x_out, bit_valid, frame_start, busy, done;

  moore_seq_gen #(
    .PAT_W     (PAT_W),
    .CNT_W     (CNT_W),
    .GAP_W     (GAP_W),
    .LFSR_SEED (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .gap_len     (gap_len),
    .x_out       (x_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // {x_out, bit_valid, frame_start, busy, done}
  typedef struct packed {
    logic x;
    logic bv;
    logic fs;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } sb_t;

  typedef struct {
    logic [PAT_W-1:0] pat;
    int               rep;
    int               gap;
    bit               hold_start;
    int               exp_busy;
    string            tag;
  } vec_t;

  sb_t        sb_q[$];
  obs_t       exp_list[$];
  obs_t       act;
  sb_t        cur;
  int         checks = 0;
  int         errors = 0;
  int         busy_seen = 0;
  logic [7:0] lfsr_m = SEED;

  assign act = {x_out, bit_valid, frame_start, busy, done};

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %b required %b (x,bv,fs,busy,done) at %0t",
                 cur.tag, act, cur.exp, $time);
      end
    end
    if (busy === 1'b1) busy_seen++;
  end

  task automatic check_now(input string tag, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic gap_fill();
`ifdef MOORE_SEQ_GEN_GAP_LFSR_EN
    logic b;
    b = lfsr_m[7];
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    return b;
`else
    return 1'b0;
`endif
  endfunction

  // Reference sequence: outputs seen on each cycle after the accepting edge.
  task automatic build(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    obs_t o;
    exp_list.delete();
    for (int r = 0; r < rep; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        o = {pat[i], 1'b1, (i == PAT_W - 1), 1'b1, 1'b0};
        exp_list.push_back(o);
      end
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) begin
          o = {gap_fill(), 1'b0, 1'b0, 1'b1, 1'b0};
          exp_list.push_back(o);
        end
    end
    exp_list.push_back(5'b00001);
    exp_list.push_back(5'b00000);
  endtask

  task automatic push(input obs_t e, input string tag);
    sb_t s;
    s.exp = e;
    s.tag = tag;
    sb_q.push_back(s);
  endtask

  task automatic run(input logic [PAT_W-1:0] pat, input int rep, input int gap,
                     input bit hold, input int exp_busy, input string tag);
    build(pat, rep, gap);
    @(negedge clk);
    start      = 1'b1;
    abort      = 1'b0;
    pattern    = pat;
    repeat_cnt = CNT_W'(rep);
    gap_len    = GAP_W'(gap);
    busy_seen  = 0;
    push(exp_list[0], $sformatf("%s[0]", tag));
    for (int k = 1; k < exp_list.size(); k++) begin
      @(negedge clk);
      start      = hold && (exp_list[k-1].busy || exp_list[k-1].done);
      pattern    = ~pat;
      repeat_cnt = ~CNT_W'(rep);
      gap_len    = ~GAP_W'(gap);
      push(exp_list[k], $sformatf("%s[%0d]", tag, k));
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_seen != exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", tag, busy_seen, exp_busy);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1011, 1, 0, 1'b0, 4, "single"};
    vecs[1] = '{4'b1011, 3, 2, 1'b1, 16, "rep3_gap2_start_held"};
    vecs[2] = '{4'b1011, 2, 0, 1'b0, 8, "rep2_b2b"};
    vecs[3] = '{4'b0110, 0, 5, 1'b0, 0, "rep0"};
    vecs[4] = '{4'b1001, 15, 15, 1'b0, 270, "max_rep_gap"};
    vecs[5] = '{4'b0001, 2, 1, 1'b1, 9, "gap1"};

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_cnt = '0; gap_len = '0;
    #12;
    check_now("reset_state", 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(5'b00000, "idle_after_reset");

    for (int v = 0; v < 6; v++)
      run(vecs[v].pat, vecs[v].rep, vecs[v].gap, vecs[v].hold_start,
          vecs[v].exp_busy, vecs[v].tag);

    // abort during the third bit of the first repetition
    @(negedge clk);
    start = 1'b1; pattern = 4'b1011; repeat_cnt = 4'd2; gap_len = 4'd0;
    push(5'b11110, "abort_b0");
    @(negedge clk); start = 1'b0; push(5'b01010, "abort_b1");
    @(negedge clk); push(5'b11010, "abort_b2");
    @(negedge clk); abort = 1'b1; push(5'b00000, "abort_next");
    @(negedge clk); abort = 1'b0; push(5'b00000, "abort_no_done");
    @(negedge clk); push(5'b00000, "abort_idle");
    run(4'b1011, 1, 0, 1'b0, 4, "after_abort");

    // abort wins over start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd1;
    push(5'b00000, "start_abort_idle");
    @(negedge clk); start = 1'b0; abort = 1'b0; push(5'b00000, "start_abort_idle2");

    // async reset in the middle of a gap
    build(4'b1011, 3, 2);
    @(negedge clk);
    start = 1'b1; pattern = 4'b1011; repeat_cnt = 4'd3; gap_len = 4'd2;
    push(exp_list[0], "rst_gap[0]");
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      push(exp_list[k], $sformatf("rst_gap[%0d]", k));
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_now("async_reset_mid_gap", 5'b00000);
    lfsr_m = SEED;
    @(negedge clk);
    rst = 1'b1;
    push(5'b00000, "post_reset_idle");
    @(negedge clk); push(5'b00000, "post_reset_no_done");
    run(4'b1011, 2, 1, 1'b0, 9, "after_reset");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/moore_seq_gen.md
Name: moore_seq_gen

Overview:
- Moore-style serial pattern transmitter. Drives a programmable PAT_W-bit pattern MSB-first onto a 1-bit serial line.
- Supports a repeat count and an optional idle gap between repetitions.
- Source end of the serial sequence-detector path: x_out feeds the detector's serial input (x) directly in benches and in the pattern-check subsystem.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 4, width of repeat count.
- GAP_W, 4, width of inter-pattern gap length.
- LFSR_SEED, 8'hA5, nonzero seed for optional gap fill (ignored if feature off).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset: asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  terminate current transfer.
- pattern  input  PAT_W  bits to send, MSB first; latched on accepted start.
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched on start.
- gap_len  input  GAP_W  gap cycles between repetitions; latched on start.
- x_out  output  1  serial data, registered.
- bit_valid  output  1  high while x_out carries a pattern bit.
- frame_start  output  1  high with the first bit of each repetition.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=0, async): state IDLE, x_out=0, bit_valid=0, frame_start=0, busy=0, done=0; bit/gap/repeat counters 0; LFSR loaded with LFSR_SEED.
- Moore: all outputs are registered functions of state and counters; none combinational from inputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 and abort=0 at edge T: latch pattern/repeat_cnt/gap_len.
  - repeat_cnt!=0 -> SEND; first bit (pattern[PAT_W-1]) on x_out in cycle after T, with bit_valid=1, frame_start=1, busy=1.
  - repeat_cnt==0 -> DONE directly; no bits sent.
- SEND:
  - One bit per cycle, index PAT_W-1 down to 0; bit_valid=1; frame_start=1 only on index PAT_W-1.
  - After index 0, decrement remaining repeats:
    - remaining==0 -> DONE.
    - gap_len==0 -> SEND, back-to-back, next bit is MSB.
    - otherwise -> GAP.
- GAP: exactly gap_len cycles; x_out=0 (see optional feature), bit_valid=0, busy=1; then SEND.
- DONE: exactly one cycle; done=1, busy=0, x_out=0, bit_valid=0; then IDLE.
- Latency: start edge to first bit = 1 cycle. Total busy cycles = repeat_cnt*PAT_W + (repeat_cnt-1)*gap_len.
- start while busy or in DONE: ignored, not queued.
- abort:
  - In SEND/GAP: IDLE at next edge; x_out=0, bit_valid=0, busy=0; no done pulse.
  - In IDLE with start: abort wins, start dropped.
  - In DONE: done still pulses.
- Input changes on pattern/repeat_cnt/gap_len after acceptance: no effect.
- Counters never wrap. Max values: repeat_cnt=2^CNT_W-1, gap_len=2^GAP_W-1.
- Async reset mid-transfer: immediate return to reset values, no done.

Optional Feature:
- Macro: MOORE_SEQ_GEN_GAP_LFSR_EN.
- Defined: x_out in GAP driven from an 8-bit Fibonacci LFSR (taps 8,6,5,4), advancing once per GAP cycle. bit_valid stays 0. LFSR state persists across transfers; reset to LFSR_SEED only by rst. This stress-tests detector false matches.
- Undefined: GAP drives x_out=0, and no LFSR logic is instantiated.

Decomposition:
- Package moore_seq_gen_pkg:
  - state typedef (IDLE, SEND, GAP, DONE), 2-bit encoding.
  - LFSR width/tap localparams.
  - Default parameter constants.
- Sub-module seq_gen_lfsr: 8-bit LFSR with enable and seed. Instantiated only under MOORE_SEQ_GEN_GAP_LFSR_EN.

Test Plan:
- pattern=4'b1011, repeat_cnt=1, gap_len=0, start pulse -> x_out 1,0,1,1 on cycles T+1..T+4; bit_valid high 4 cycles; frame_start only at T+1; done at T+5; busy low at T+5.
- pattern=4'b1011, repeat_cnt=3, gap_len=2 -> x_out 1011 00 1011 00 1011 (16 busy cycles); 3 frame_start pulses; done at T+17. With macro: gap bits match the LFSR reference model and bit_valid=0 in gaps.
- pattern=4'b1011, repeat_cnt=2, gap_len=0 -> 10111011 contiguous; frame_start at T+1 and T+5; done at T+9.
- repeat_cnt=0, start -> no bit_valid; done at T+1; busy never high.
- abort at third bit of first repetition (repeat_cnt=2) -> x_out=0 and busy=0 next cycle; no done; new start 2 cycles later sends full 1011.
- rst low mid-GAP, plus start asserted during SEND -> all outputs 0 immediately on rst; start during SEND has no effect on bit count.
